// File: rtl/tmul_row_seq_if.sv
// Handshake and data bundle between the row sequencer, its producer/consumer and the row FMA.
// The slave side is the sequencer; the master side is everything around it.
interface tmul_row_seq_if #(
    parameter int K_MAX = 16,
    parameter int LANES = 32,
    parameter int W     = 16
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = LANES * W;

    logic          start;
    logic [KW-1:0] k_len;
    logic [RW-1:0] c_init;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [RW-1:0] in_b;
    logic [W-1:0]  fma_a;
    logic [RW-1:0] fma_b;
    logic [RW-1:0] fma_c;
    logic [RW-1:0] fma_product;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic          busy;

    modport slave (
        input  start, k_len, c_init, in_valid, in_a, in_b, fma_product, out_ready,
        output in_ready, fma_a, fma_b, fma_c, out_valid, out_row, busy
    );

    modport master (
        output start, k_len, c_init, in_valid, in_a, in_b, fma_product, out_ready,
        input  in_ready, fma_a, fma_b, fma_c, out_valid, out_row, busy
    );
endinterface

// File: rtl/tmul_row_seq.sv
// Row sequencer for the combinational row FMA: feeds one A scalar and one B row per
// pair, folds the FMA result back into a 512-bit accumulator and hands the row out.
module tmul_row_seq #(
    parameter int K_MAX = 16,
    parameter int LANES = 32,
    parameter int W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    tmul_row_seq_if.slave  bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int RW = LANES * W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q,     state_d;
    logic [W-1:0]  fma_a_q,     fma_a_d;
    logic [RW-1:0] fma_b_q,     fma_b_d;
    logic [RW-1:0] acc_q,       acc_d;
    logic [KW-1:0] kcnt_q,      kcnt_d;
    logic [KW-1:0] klen_q,      klen_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q,      busy_d;
    logic [KW-1:0] klen_clamped_s;
    logic          last_pair_s;

    // Next-state and datapath computation; the handshake flags are derived from the next
    // state so they line up with the state register and need no output decode.
    always_comb begin
        state_d        = state_q;
        fma_a_d        = fma_a_q;
        fma_b_d        = fma_b_q;
        acc_d          = acc_q;
        kcnt_d         = kcnt_q;
        klen_d         = klen_q;
        klen_clamped_s = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
        last_pair_s    = ((kcnt_q + KW'(1)) == klen_q);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d  = bus.c_init;
                    kcnt_d = {KW{1'b0}};
                    klen_d = klen_clamped_s;
                    if (klen_clamped_s == {KW{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.in_valid && in_ready_q) begin
                    fma_a_d = bus.in_a;
                    fma_b_d = bus.in_b;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_EXEC: begin
                // fma_product is combinational from fma_a/fma_b/acc, captured here in one cycle
                acc_d  = bus.fma_product;
                kcnt_d = kcnt_q + KW'(1);
                if (last_pair_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_RUN);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fma_a_q     <= {W{1'b0}};
            fma_b_q     <= {RW{1'b0}};
            acc_q       <= {RW{1'b0}};
            kcnt_q      <= {KW{1'b0}};
            klen_q      <= {KW{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fma_a_q     <= fma_a_d;
            fma_b_q     <= fma_b_d;
            acc_q       <= acc_d;
            kcnt_q      <= kcnt_d;
            klen_q      <= klen_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.fma_a     = fma_a_q;
    assign bus.fma_b     = fma_b_q;
    assign bus.fma_c     = acc_q;
    assign bus.out_row   = acc_q;
endmodule

// File: doc/tmul_row_seq.md
# tmul_row_seq

Sequencer that drives the combinational FP16/BF16 row FMA (`FMA_Row`). It sits directly upstream of the FMA and also consumes its output, computing C[m][:] += Σk A[m][k]·B[k][:] for one tile row. Each cycle pair it broadcasts one A scalar and one 32-lane B row into the FMA and feeds back its own 512-bit accumulator as the C row. It captures the FMA product into that accumulator, then returns the finished row over a valid/ready port.

## Interface
- `K_MAX`, 16, maximum reduction depth per row
- `LANES`, 32, FMA lanes (fixed by `FMA_Row`)
- `W`, 16, element width (FP16/BF16 bit pattern)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; one clock, asynchronous and active-high
- `start`  in  1  begin a row; sampled only in IDLE
- `k_len`  in  $clog2(K_MAX+1)  reduction depth, captured on `start`
- `c_init`  in  LANES*W  initial C row, captured on `start`
- `in_valid`  in  1  A/B element pair available
- `in_ready`  out  1  sequencer accepts A/B pair
- `in_a`  in  W  A[m][k] scalar
- `in_b`  in  LANES*W  B[k] row, lane i at bits [(i+1)*W-1 : i*W]
- `fma_a`  out  W  registered scalar to FMA `a`
- `fma_b`  out  LANES*W  registered row to FMA `RowB`
- `fma_c`  out  LANES*W  accumulator to FMA `RowC`
- `fma_product`  in  LANES*W  FMA `Row_product`, combinational from fma_*
- `out_valid`  out  1  result row valid
- `out_ready`  in  1  consumer accepts result
- `out_row`  out  LANES*W  result row, equal to the accumulator
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, RUN, EXEC, DONE.
- IDLE, when `start`=1:
  - `acc`<=`c_init`; `kcnt`<=0.
  - `klen_r`<=min(`k_len`,K_MAX).
  - Next state is DONE if the clamped length is 0, otherwise RUN.
- RUN:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: `fma_a`<=`in_a`, `fma_b`<=`in_b`, then go to EXEC.
  - Without a handshake, stay in RUN and hold all registers.
- EXEC:
  - `in_ready`=0.
  - `acc`<=`fma_product`; `kcnt`<=`kcnt`+1.
  - Next state is DONE if `kcnt`==`klen_r`-1, otherwise RUN.
- DONE:
  - `out_valid`=1.
  - On `out_ready`, go to IDLE; `acc` is retained (not cleared).
- Outputs: `fma_c`=`acc` and `out_row`=`acc`, both combinational from the register.
- `start` outside IDLE is ignored and has no side effect.
- `fma_a`/`fma_b` hold their last values outside EXEC.
- Arithmetic is done entirely by the FMA. The block never inspects or alters element bits, so mode (FP16/BF16/INT8) is transparent.
- `kcnt` is `$clog2(K_MAX+1)` bits and never wraps, because the clamp bounds it at K_MAX.

## Timing
- Reset (async assert, sync release):
  - state=IDLE.
  - `in_ready`=0, `out_valid`=0, `busy`=0.
  - `fma_a`=0, `fma_b`=0, `acc`=0, so `fma_c`=0 and `out_row`=0.
  - `kcnt`=0, `klen_r`=0.
- Reset mid-operation aborts the row with no output. An in-flight `in_valid` beat is not consumed.
- Latency, with `in_valid` held high: `out_valid` rises 2·k_len+1 cycles after the `start` edge. Each RUN stall cycle adds 1.
- k_len=0: `out_valid` rises 1 cycle after `start`, with `out_row`=`c_init`.
- Throughput: one A/B pair per 2 cycles, and at most one pair in flight.
- The FMA path `fma_*`→`fma_product`→`acc` is a single-cycle combinational path inside EXEC.
- `out_valid` and `out_row` stay stable while `out_ready`=0.
- A new `start` is accepted the cycle after the DONE→IDLE handshake, never in the same cycle.

## Test plan
- k_len=1, c_init=0, in_a=16'h3C00, all in_b lanes=16'h4000 → out_valid 3 cycles after start, every lane 16'h4000.
- k_len=2, c_init lanes=16'h3C00; pairs (3C00,3C00), then (3C00,4000) → every lane 16'h4400 (1+1+2=4.0); out_valid at cycle 5.
- k_len=0, c_init lane i=i → out_valid 1 cycle after start; out_row equals c_init; in_ready never asserted.
- k_len=3 with in_valid low for 4 cycles before the 2nd pair → out_valid at cycle 11. start pulses while busy are ignored. The result matches the no-stall run.
- out_ready held low 6 cycles in DONE → out_valid and out_row stable, then IDLE after the handshake. k_len=31 clamps to 16 pairs.
- rst asserted in EXEC of pair 2 of 4 → all outputs 0 immediately, state IDLE, no out_valid. A following k_len=1 row is correct.
